bus_txn_controller: RTL and testbench

- Downstream stage of the bus arbiter: consumes its one-hot grant vector, latches the granted master's request and drives it onto the shared slave bus.
- Holds the transaction until the slave responds or a watchdog expires, then returns a one-cycle completion pulse, read data and error status to the originating master.
- busy is exported so that masters can hold off new requests while a transaction is in flight.

---
 rtl/bus_pkg.sv | 30 +++
 rtl/bus_txn_controller.sv | 148 ++++++++++++++
 tb/tb_bus_txn_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus-side types: FSM state encoding, default field widths and a one-hot decoder.
// Pure declarations; no latency or flow-control behaviour of its own.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Returns {valid, index}; valid only when exactly one bit of vec is set.
    // Narrower grant vectors are zero-extended by the caller.
    function automatic logic [5:0] onehot_index(input logic [31:0] vec);
        logic [4:0]  idx;
        int unsigned ones;
        idx  = '0;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                ones++;
                idx = 5'(i);
            end
        end
        return {(ones == 1), idx};
    endfunction

endpackage

// File: rtl/bus_txn_controller.sv
// Latches the granted master's request onto the slave bus and returns done/rdata/err.
// Grant to bus_valid 1 cycle, s_ready to m_done 1 cycle; busy holds off masters, watchdog bounds slave stalls.
module bus_txn_controller
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        grant,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic                          bus_valid,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_wdata,
    output logic                          bus_we,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_err,
    output logic                          busy,
    output logic                          grant_err
);

    localparam int         IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]      bus_wdata_q, bus_wdata_d;
    logic                   bus_we_q, bus_we_d;
    logic [NUM_MASTERS-1:0] m_done_q, m_done_d;
    logic [DATA_W-1:0]      m_rdata_q, m_rdata_d;
    logic                   m_err_q, m_err_d;
    logic                   busy_q, busy_d;
    logic                   grant_err_q, grant_err_d;

    logic [31:0] grant_ext;
    logic        oh_vld;
    logic [4:0]  oh_idx;

    always_comb begin
        grant_ext                    = '0;
        grant_ext[NUM_MASTERS-1:0]   = grant;
    end

    assign {oh_vld, oh_idx} = onehot_index(grant_ext);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        m_done_d    = '0;
        m_rdata_d   = m_rdata_q;
        m_err_d     = m_err_q;
        busy_d      = busy_q;
        grant_err_d = grant_err_q;

        unique case (state_q)
            IDLE: begin
                if (oh_vld) begin
                    idx_d       = oh_idx[IDX_W-1:0];
                    bus_addr_d  = m_addr[int'(oh_idx)*ADDR_W +: ADDR_W];
                    bus_wdata_d = m_wdata[int'(oh_idx)*DATA_W +: DATA_W];
                    bus_we_d    = m_we[oh_idx];
                    bus_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end else if (grant != '0) begin
                    grant_err_d = 1'b1;
                end
            end
            ISSUE: begin
                // A response on the watchdog's last cycle still counts as a normal completion.
                if (s_ready || (cnt_q == CNT_LAST)) begin
                    m_rdata_d       = s_ready ? s_rdata : '0;
                    m_err_d         = ~s_ready;
                    m_done_d[idx_q] = 1'b1;
                    bus_valid_d     = 1'b0;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            m_done_q    <= '0;
            m_rdata_q   <= '0;
            m_err_q     <= 1'b0;
            busy_q      <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            m_done_q    <= m_done_d;
            m_rdata_q   <= m_rdata_d;
            m_err_q     <= m_err_d;
            busy_q      <= busy_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign m_done    = m_done_q;
    assign m_rdata   = m_rdata_q;
    assign m_err     = m_err_q;
    assign busy      = busy_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_bus_txn_controller.sv
// Directed bench for bus_txn_controller: transaction-level model checked every cycle plus literal spot checks.
module tb_bus_txn_controller;

    localparam int NM      = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  grant;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    logic        s_ready;
    logic [7:0]  s_rdata;
    logic        bus_valid;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic [3:0]  m_done;
    logic [7:0]  m_rdata;
    logic        m_err;
    logic        busy;
    logic        grant_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    bus_txn_controller #(
        .NUM_MASTERS(NM), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .grant(grant), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_we(m_we), .s_ready(s_ready), .s_rdata(s_rdata), .bus_valid(bus_valid),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .m_done(m_done),
        .m_rdata(m_rdata), .m_err(m_err), .busy(busy), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding request, its elapsed wait, and a closing beat.
    bit         t_active, t_closing;
    int         t_idx, t_waited;
    logic       e_bv, e_we, e_err, e_busy, e_gerr;
    logic [7:0] e_addr, e_wdata, e_rdata;
    logic [3:0] e_done;

    always @(posedge clk) begin
        if (reset) begin
            t_active = 0; t_closing = 0; t_idx = 0; t_waited = 0;
            e_bv = 0; e_we = 0; e_err = 0; e_busy = 0; e_gerr = 0;
            e_addr = 0; e_wdata = 0; e_rdata = 0; e_done = 0;
        end else if (t_closing) begin
            t_closing = 0;
            e_done    = 0;
            e_busy    = 0;
        end else if (t_active) begin
            if (s_ready || t_waited == TIMEOUT - 1) begin
                e_rdata   = s_ready ? s_rdata : 8'h00;
                e_err     = !s_ready;
                e_done    = 4'b0001 << t_idx;
                e_bv      = 0;
                t_active  = 0;
                t_closing = 1;
            end else begin
                t_waited++;
            end
        end else if ($countones(grant) == 1) begin
            for (int i = 0; i < NM; i++) if (grant[i]) t_idx = i;
            e_addr   = m_addr[t_idx*8 +: 8];
            e_wdata  = m_wdata[t_idx*8 +: 8];
            e_we     = m_we[t_idx];
            e_bv     = 1;
            e_busy   = 1;
            t_active = 1;
            t_waited = 0;
        end else if (grant != 0) begin
            e_gerr = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bus_valid", {31'b0, bus_valid}, {31'b0, e_bv});
            chk("bus_addr",  {24'b0, bus_addr},  {24'b0, e_addr});
            chk("bus_wdata", {24'b0, bus_wdata}, {24'b0, e_wdata});
            chk("bus_we",    {31'b0, bus_we},    {31'b0, e_we});
            chk("m_done",    {28'b0, m_done},    {28'b0, e_done});
            chk("m_rdata",   {24'b0, m_rdata},   {24'b0, e_rdata});
            chk("m_err",     {31'b0, m_err},     {31'b0, e_err});
            chk("busy",      {31'b0, busy},      {31'b0, e_busy});
            chk("grant_err", {31'b0, grant_err}, {31'b0, e_gerr});
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int vc;

    initial begin
        reset = 1; grant = 0; m_addr = 0; m_wdata = 0; m_we = 0; s_ready = 0; s_rdata = 0;
        tick; tick;
        cmp_en = 1;
        reset  = 0;
        chk("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
        chk("rst_grant_err", {31'b0, grant_err}, 32'd0);
        chk("rst_bus_addr",  {24'b0, bus_addr},  32'd0);

        // 1: write from master 0, slave ready on first ISSUE cycle
        m_addr[7:0] = 8'h3C; m_wdata[7:0] = 8'hA5; m_we[0] = 1; grant = 4'b0001;
        tick;
        grant = 0; s_ready = 1;
        chk("t1_bus_valid", {31'b0, bus_valid}, 32'd1);
        chk("t1_bus_addr",  {24'b0, bus_addr},  32'h3C);
        chk("t1_bus_wdata", {24'b0, bus_wdata}, 32'hA5);
        chk("t1_bus_we",    {31'b0, bus_we},    32'd1);
        tick;
        s_ready = 0;
        chk("t1_m_done",    {28'b0, m_done},    32'b0001);
        chk("t1_m_err",     {31'b0, m_err},     32'd0);
        chk("t1_bus_valid_off", {31'b0, bus_valid}, 32'd0);
        tick;

        // 2: read from master 2 after three wait cycles
        m_addr[23:16] = 8'h10; m_we[2] = 0; grant = 4'b0100;
        tick;
        grant = 0;
        vc = 0;
        repeat (3) begin
            chk("t2_busy", {31'b0, busy}, 32'd1);
            vc += int'(bus_valid);
            tick;
        end
        vc += int'(bus_valid);
        s_ready = 1; s_rdata = 8'h5E;
        tick;
        s_ready = 0; s_rdata = 8'h00;
        chk("t2_valid_cycles", vc, 32'd4);
        chk("t2_m_done",  {28'b0, m_done},  32'b0100);
        chk("t2_m_rdata", {24'b0, m_rdata}, 32'h5E);
        chk("t2_busy_done", {31'b0, busy}, 32'd1);
        tick;

        // 3: master 1 never answered -> watchdog completion
        grant = 4'b0010; s_rdata = 8'hC3;
        tick;
        grant = 0;
        vc = 0;
        for (int n = 0; n < 40 && m_done == 0; n++) begin
            vc += int'(bus_valid);
            tick;
        end
        chk("t3_valid_cycles", vc, 32'd16);
        chk("t3_m_done",  {28'b0, m_done},  32'b0010);
        chk("t3_m_err",   {31'b0, m_err},   32'd1);
        chk("t3_m_rdata", {24'b0, m_rdata}, 32'h00);
        tick;
        chk("t3_idle_busy", {31'b0, busy}, 32'd0);

        // 4: illegal grant is sticky and issues nothing
        grant = 4'b0110;
        tick;
        grant = 0;
        chk("t4_grant_err", {31'b0, grant_err}, 32'd1);
        chk("t4_no_valid",  {31'b0, bus_valid}, 32'd0);
        tick;
        m_addr[31:24] = 8'h77; grant = 4'b1000;
        tick;
        grant = 0; s_ready = 1;
        chk("t4_bus_addr", {24'b0, bus_addr}, 32'h77);
        tick;
        s_ready = 0;
        chk("t4_m_done",    {28'b0, m_done},    32'b1000);
        chk("t4_gerr_held", {31'b0, grant_err}, 32'd1);
        tick;

        // 5: inputs change while issuing are ignored
        m_addr[7:0] = 8'h22; grant = 4'b0001;
        tick;
        grant = 4'b1000; m_addr[7:0] = 8'hFF;
        tick;
        chk("t5_bus_addr", {24'b0, bus_addr}, 32'h22);
        s_ready = 1;
        tick;
        grant = 0; s_ready = 0;
        chk("t5_m_done", {28'b0, m_done}, 32'b0001);
        tick;

        // 6: reset mid-transaction, then a response landing on the watchdog's last cycle
        grant = 4'b0001;
        tick;
        grant = 0;
        tick;
        reset = 1;
        tick;
        reset = 0;
        chk("t6_rst_valid",  {31'b0, bus_valid}, 32'd0);
        chk("t6_rst_busy",   {31'b0, busy},      32'd0);
        chk("t6_rst_done",   {28'b0, m_done},    32'd0);
        chk("t6_rst_gerr",   {31'b0, grant_err}, 32'd0);
        grant = 4'b0100;
        tick;
        grant = 0;
        repeat (15) tick;
        chk("t6_still_valid", {31'b0, bus_valid}, 32'd1);
        s_ready = 1; s_rdata = 8'h99;
        tick;
        s_ready = 0;
        chk("t6_m_done",  {28'b0, m_done},  32'b0100);
        chk("t6_m_err",   {31'b0, m_err},   32'd0);
        chk("t6_m_rdata", {24'b0, m_rdata}, 32'h99);
        tick; tick;

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
